// File: rtl/fetch_sequencer_if.sv
// Fetch-side bundle: instruction-memory request port, decode-facing
// instruction port and the branch/halt control from downstream stages.
interface fetch_sequencer_if #(
  parameter int AW = 16,
  parameter int IW = 16
);
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [IW-1:0] imem_rdata;
  logic [IW-1:0] inst;
  logic [AW-1:0] inst_pc;
  logic          inst_valid;
  logic          stall;
  logic          branch;
  logic [AW-1:0] branch_addr;
  logic          halt;
  logic          resume;
  logic          halted;

  modport master (
    output imem_req, imem_addr, inst, inst_pc, inst_valid, halted,
    input  imem_ack, imem_rdata, stall, branch, branch_addr, halt, resume
  );

  modport slave (
    input  imem_req, imem_addr, inst, inst_pc, inst_valid, halted,
    output imem_ack, imem_rdata, stall, branch, branch_addr, halt, resume
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, issues one imem request at a
// time and hands clean in-order instructions to decode.
module fetch_sequencer #(
  parameter int INST_ADDR_WIDTH   = 16,
  parameter int INST_WIDTH        = 16,
  parameter int NUM_BYTES_IN_INST = 2,
  parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  fetch_sequencer_if.master fs
);
  localparam logic [INST_ADDR_WIDTH-1:0] PC_INC = INST_ADDR_WIDTH'(NUM_BYTES_IN_INST);

  typedef enum logic [1:0] {IDLE, FETCH, FULL, HALTED} state_e;

  state_e                     state_q, state_d;
  logic [INST_ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic                       pending_valid_q, pending_valid_d;
  logic [INST_ADDR_WIDTH-1:0] pending_addr_q, pending_addr_d;
  logic [INST_WIDTH-1:0]      inst_q, inst_d;
  logic [INST_ADDR_WIDTH-1:0] inst_pc_q, inst_pc_d;
  logic                       inst_valid_q, inst_valid_d;
  logic                       imem_req_q, imem_req_d;
  logic                       halted_q, halted_d;

  always_comb begin
    state_d         = state_q;
    fetch_pc_d      = fetch_pc_q;
    pending_valid_d = pending_valid_q;
    pending_addr_d  = pending_addr_q;
    inst_d          = inst_q;
    inst_pc_d       = inst_pc_q;
    inst_valid_d    = inst_valid_q;
    unique case (state_q)
      IDLE: state_d = fs.halt ? HALTED : FETCH;
      FETCH: begin
        // The request is never retracted; a redirect seen during it only
        // poisons the returning data and retargets the next request.
        if (fs.imem_ack) begin
          if (pending_valid_q || fs.branch) begin
            fetch_pc_d      = fs.branch ? fs.branch_addr : pending_addr_q;
            pending_valid_d = 1'b0;
          end else begin
            inst_d       = fs.imem_rdata;
            inst_pc_d    = fetch_pc_q;
            inst_valid_d = 1'b1;
            fetch_pc_d   = fetch_pc_q + PC_INC;
            state_d      = FULL;
          end
        end else if (fs.branch) begin
          pending_valid_d = 1'b1;
          pending_addr_d  = fs.branch_addr;
        end
      end
      FULL: begin
        if (fs.branch || !fs.stall) begin
          inst_valid_d = 1'b0;
          if (fs.branch) fetch_pc_d = fs.branch_addr;
          state_d = fs.halt ? HALTED : FETCH;
        end
      end
      HALTED: begin
        if (fs.branch) fetch_pc_d = fs.branch_addr;
        if (fs.resume) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
    imem_req_d = (state_d == FETCH);
    halted_d   = (state_d == HALTED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      fetch_pc_q      <= RESET_PC;
      pending_valid_q <= 1'b0;
      pending_addr_q  <= '0;
      inst_q          <= '0;
      inst_pc_q       <= '0;
      inst_valid_q    <= 1'b0;
      imem_req_q      <= 1'b0;
      halted_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      fetch_pc_q      <= fetch_pc_d;
      pending_valid_q <= pending_valid_d;
      pending_addr_q  <= pending_addr_d;
      inst_q          <= inst_d;
      inst_pc_q       <= inst_pc_d;
      inst_valid_q    <= inst_valid_d;
      imem_req_q      <= imem_req_d;
      halted_q        <= halted_d;
    end
  end

  assign fs.imem_req   = imem_req_q;
  assign fs.imem_addr  = fetch_pc_q;
  assign fs.inst       = inst_q;
  assign fs.inst_pc    = inst_pc_q;
  assign fs.inst_valid = inst_valid_q;
  assign fs.halted     = halted_q;
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller that owns the architectural program counter and sequences next-PC selection (increment, branch redirect, halt hold) against a request/acknowledge instruction-memory port. It sits between instruction memory and the decode stage, presents one fetched instruction at a time with a valid/stall handshake, and reacts to branch redirects from execute and halt/resume control. Multi-cycle memory latency, flushes and halting are handled here so the downstream pipeline sees only clean, in-order instructions.

## Interface
- INST_ADDR_WIDTH, 16, width of PC and instruction addresses
- INST_WIDTH, 16, width of an instruction word
- NUM_BYTES_IN_INST, 2, PC increment per sequential fetch
- RESET_PC, 0, fetch address after reset
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- imem_req  output  1  fetch request; held high until imem_ack
- imem_addr  output  INST_ADDR_WIDTH  fetch address; stable while imem_req=1
- imem_ack  input  1  request complete; imem_rdata valid this cycle (same-cycle ack allowed)
- imem_rdata  input  INST_WIDTH  fetched instruction word
- inst  output  INST_WIDTH  instruction presented to decode
- inst_pc  output  INST_ADDR_WIDTH  address of inst
- inst_valid  output  1  inst/inst_pc valid
- stall  input  1  decode cannot accept; instruction consumed on cycle with inst_valid=1, stall=0
- branch  input  1  one-cycle redirect pulse from execute
- branch_addr  input  INST_ADDR_WIDTH  redirect target, used as-is
- halt  input  1  halt request level from decode
- resume  input  1  one-cycle pulse leaving HALTED
- halted  output  1  high while in HALTED

## Operation
- States: IDLE, FETCH, FULL, HALTED. Registered fetch_pc, pending_valid, pending_addr.
- Reset: state=IDLE, fetch_pc=RESET_PC, pending cleared; imem_req=0, imem_addr=RESET_PC, inst=0, inst_pc=0, inst_valid=0, halted=0.
- IDLE: outputs quiet; next state FETCH unconditionally (halt in IDLE goes to HALTED instead).
- FETCH: imem_req=1, imem_addr=fetch_pc. Without ack: remain; a branch pulse sets pending_valid, pending_addr=branch_addr (latest pulse wins); address does not change.
- FETCH with ack, no redirect (pending_valid=0, branch=0): inst<=imem_rdata, inst_pc<=fetch_pc, inst_valid<=1, fetch_pc<=fetch_pc+NUM_BYTES_IN_INST, go FULL.
- FETCH with ack and redirect (pending_valid=1 or branch=1): data discarded, inst_valid stays 0, fetch_pc<=branch_addr if branch=1 else pending_addr, pending cleared, stay FETCH (new address next cycle).
- FULL: imem_req=0, inst held. Consumed (stall=0): inst_valid<=0; go HALTED if halt=1, else FETCH. Not consumed: hold everything.
- Branch in FULL: flush; inst_valid<=0, fetch_pc<=branch_addr; go HALTED if halt=1, else FETCH. Branch overrides stall.
- Halt in FETCH: not sampled; transaction always completes, halt honored in FULL.
- HALTED: halted=1, imem_req=0, inst_valid=0, fetch_pc frozen. Branch still updates fetch_pc. resume=1: go FETCH from fetch_pc. halt ignored here.
- Priority: rst > branch > halt > sequential increment.
- Arithmetic: increment modulo 2^INST_ADDR_WIDTH; 0xFFFE+2 wraps to 0x0000, no flag.

## Timing
- Reset to first imem_req: 1 cycle (IDLE then FETCH).
- Same-cycle ack: 2 cycles per instruction (FETCH 1, FULL 1) with stall=0.
- inst_valid rises on the edge after ack; drops on the edge after consumption or flush.
- Redirect: target appears on imem_addr the cycle after it is applied (at ack in FETCH, immediately in FULL/HALTED).
- halted rises the edge after consumption with halt=1; falls the edge after resume.
- rst mid-transaction: abandons request; imem_req low the next cycle; late acks while in IDLE ignored.

## Test plan
- Reset, imem_ack tied high, stall=0: imem_addr 0x0000,0x0002,0x0004 on alternate cycles; inst_pc matches; inst_valid pulses every 2 cycles.
- Ack delayed 3 cycles with branch to 0x0040 in second wait cycle: imem_addr stays 0x0002 until ack, data dropped (inst_valid=0), next request at 0x0040.
- stall held 4 cycles in FULL: inst, inst_pc, inst_valid=1 stable, imem_req=0; release -> next fetch at inst_pc+2.
- halt=1 with consumption of 0x0010: halted=1, no requests for 10 cycles; resume pulse -> imem_addr 0x0012.
- RESET_PC=0xFFFE: fetches 0xFFFE then 0x0000.
- rst asserted while imem_req=1 waiting: next cycle imem_req=0, inst_valid=0, then fetch restarts at RESET_PC.
